// File: rtl/subpix_window_feeder_pkg.sv
// Shared definitions for the sub-pixel window feeder.
//   - Default pixel / fractional / pair-select widths.
//   - win_len(): window length derived from the pair-select width.
//   - feeder_state_e: line sequencing states.
package subpix_window_feeder_pkg;

  localparam int unsigned DefDataDepth   = 8;
  localparam int unsigned DefSubpixDepth = 5;
  localparam int unsigned DefSelDepth    = 1;

  // Window length WL = 2**sel_depth + 1 (one pixel pair per select step plus the right neighbour).
  function automatic int unsigned win_len(input int unsigned sel_depth);
    return (32'd1 << sel_depth) + 32'd1;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StEmit,
    StDrain
  } feeder_state_e;

endpackage

// File: rtl/subpix_pix_buffer.sv
// Small shift buffer of WL+1 pixels holding a contiguous run of line pixels.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           drop all contents and restart pixel indexing at 0
//   pop_n           number of oldest pixels to discard this cycle
//   push/push_data  append one pixel after the pops
//   skip            an incoming pixel is dropped without storing (head advances)
//   rd_base         window start, relative to the current head
//   rd_window       WL pixels from rd_base; reads past the newest entry return the newest
//   count, head     number of held pixels, line index of the oldest held pixel
module subpix_pix_buffer #(
  parameter int unsigned DATA_DEPTH = 8,
  parameter int unsigned WL         = 3,
  parameter int unsigned IDX_W      = 16,
  localparam int unsigned Depth     = WL + 1,
  localparam int unsigned CntW      = $clog2(Depth + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [CntW-1:0]          pop_n,
  input  logic                     push,
  input  logic [DATA_DEPTH-1:0]    push_data,
  input  logic                     skip,
  input  logic [CntW-1:0]          rd_base,
  output logic [WL*DATA_DEPTH-1:0] rd_window,
  output logic [CntW-1:0]          count,
  output logic [IDX_W-1:0]         head
);

  logic [DATA_DEPTH-1:0] mem_q [Depth];
  logic [DATA_DEPTH-1:0] mem_d [Depth];
  logic [CntW-1:0]       count_q, count_d, count_ap;
  logic [IDX_W-1:0]      head_q, head_d;

  always_comb begin
    count_ap = count_q - pop_n;
    for (int j = 0; j < int'(Depth); j++) begin
      mem_d[j] = mem_q[j];
      for (int s = 0; s < int'(Depth); s++) begin
        if (s == j + int'(pop_n)) mem_d[j] = mem_q[s];
      end
    end
    if (push) begin
      for (int j = 0; j < int'(Depth); j++) begin
        if (j == int'(count_ap)) mem_d[j] = push_data;
      end
    end
    count_d = count_ap + CntW'(push);
    head_d  = head_q + IDX_W'(pop_n) + IDX_W'(skip);
    if (clear) begin
      count_d = '0;
      head_d  = '0;
    end
  end

  // Clamp read: anything beyond the newest entry returns the newest entry (line edge).
  always_comb begin
    int r;
    int lastp;
    rd_window = '0;
    lastp = (count_q == '0) ? 0 : int'(count_q) - 1;
    for (int k = 0; k < int'(WL); k++) begin
      r = int'(rd_base) + k;
      if (r > lastp) r = lastp;
      for (int s = 0; s < int'(Depth); s++) begin
        if (s == r) rd_window[k*DATA_DEPTH +: DATA_DEPTH] = mem_q[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      for (int j = 0; j < int'(Depth); j++) mem_q[j] <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      for (int j = 0; j < int'(Depth); j++) mem_q[j] <= mem_d[j];
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/subpix_window_feeder.sv
// Feeds pixel windows to a sub-pixel interpolator along one line.
// Each output n has position P = pos0 + n*step; the window starts at pixel
// B = (P >> (SEL_DEPTH+SUBPIX_DEPTH)) << SEL_DEPTH and the fractional part goes out as out_interp.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cfg_start/pos0/step/nout         line setup, latched when idle
//   in_valid/in_ready/in_pix/in_last input pixel stream
//   out_valid/out_ready              output handshake
//   out_data_col                     window, pixel B+k at bits [k*DATA_DEPTH +: DATA_DEPTH]
//   out_interp, out_last             interpolation code, last output of the line
//   busy                             line in progress
module subpix_window_feeder
  import subpix_window_feeder_pkg::*;
#(
  parameter int unsigned DATA_DEPTH   = DefDataDepth,
  parameter int unsigned SUBPIX_DEPTH = DefSubpixDepth,
  parameter int unsigned SEL_DEPTH    = DefSelDepth,
  parameter int unsigned POS_W        = 16,
  localparam int unsigned WL          = win_len(SEL_DEPTH),
  localparam int unsigned IntW        = SEL_DEPTH + SUBPIX_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic [POS_W-1:0]         cfg_pos0,
  input  logic [POS_W-1:0]         cfg_step,
  input  logic [11:0]              cfg_nout,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_DEPTH-1:0]    in_pix,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WL*DATA_DEPTH-1:0] out_data_col,
  output logic [IntW-1:0]          out_interp,
  output logic                     out_last,
  output logic                     busy
);

  localparam int unsigned Depth = WL + 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  feeder_state_e            state_q;
  logic [POS_W-1:0]         pos_q, step_q;
  logic [11:0]              rem_q;
  logic                     last_seen_q;
  logic [WL*DATA_DEPTH-1:0] out_data_q;
  logic [IntW-1:0]          out_interp_q;
  logic                     out_last_q;

  logic [POS_W-1:0]         pos_nxt, base, base_nxt, gap, head_ap, in_idx;
  logic [CntW-1:0]          keep, pop_n, count_ap, buf_pop;
  logic [CntW-1:0]          buf_count;
  logic [POS_W-1:0]         buf_head;
  logic [WL*DATA_DEPTH-1:0] rd_window;
  logic                     win_ready, in_acc, start_acc, buf_push, buf_skip;

  assign pos_nxt  = pos_q + step_q;
  assign base     = (pos_q >> IntW) << SEL_DEPTH;
  assign base_nxt = (pos_nxt >> IntW) << SEL_DEPTH;

  always_comb begin
    gap = (base > buf_head) ? (base - buf_head) : '0;
    // Once the line end is known the last pixel is kept for edge clamping.
    keep = (last_seen_q && (buf_count != '0)) ? (buf_count - CntW'(1)) : buf_count;
    pop_n = (gap < POS_W'(keep)) ? gap[CntW-1:0] : keep;
    count_ap = buf_count - pop_n;
    head_ap  = buf_head + POS_W'(pop_n);
    win_ready = ((head_ap >= base) || (last_seen_q && (count_ap == CntW'(1)))) &&
                ((count_ap >= CntW'(WL)) || last_seen_q);
  end

  assign in_idx    = buf_head + POS_W'(buf_count);
  assign in_ready  = ((state_q == StFill) && !win_ready && !last_seen_q &&
                      (count_ap < CntW'(Depth))) ||
                     ((state_q == StDrain) && !last_seen_q);
  assign in_acc    = in_valid && in_ready;
  assign start_acc = (state_q == StIdle) && cfg_start;
  assign buf_pop   = (state_q == StFill) ? pop_n : '0;
  // Pixels left of the window are dropped unless they end the line.
  assign buf_push  = in_acc && (state_q == StFill) && ((in_idx >= base) || in_last);
  assign buf_skip  = in_acc && (state_q == StFill) && !buf_push;

  subpix_pix_buffer #(
    .DATA_DEPTH(DATA_DEPTH),
    .WL        (WL),
    .IDX_W     (POS_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_acc),
    .pop_n    (buf_pop),
    .push     (buf_push),
    .push_data(in_pix),
    .skip     (buf_skip),
    .rd_base  (pop_n),
    .rd_window(rd_window),
    .count    (buf_count),
    .head     (buf_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pos_q        <= '0;
      step_q       <= '0;
      rem_q        <= '0;
      last_seen_q  <= 1'b0;
      out_data_q   <= '0;
      out_interp_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      if (in_acc && in_last) last_seen_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (cfg_start) begin
            pos_q       <= cfg_pos0;
            step_q      <= cfg_step;
            rem_q       <= cfg_nout;
            last_seen_q <= 1'b0;
            state_q     <= (cfg_nout == '0) ? StDrain : StFill;
          end
        end
        StFill: begin
          if (win_ready) begin
            state_q      <= StEmit;
            out_data_q   <= rd_window;
            out_interp_q <= pos_q[IntW-1:0];
            out_last_q   <= (rem_q == 12'd1);
          end
        end
        StEmit: begin
          if (out_ready) begin
            rem_q <= rem_q - 12'd1;
            pos_q <= pos_nxt;
            if (rem_q == 12'd1) begin
              out_last_q <= 1'b0;
              state_q    <= last_seen_q ? StIdle : StDrain;
            end else if (base_nxt == base) begin
              // Same window: re-emit directly without consuming input.
              out_interp_q <= pos_nxt[IntW-1:0];
              out_last_q   <= (rem_q == 12'd2);
            end else begin
              state_q <= StFill;
            end
          end
        end
        StDrain: begin
          if (in_acc && in_last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid    = (state_q == StEmit);
  assign busy         = (state_q != StIdle);
  assign out_data_col = out_data_q;
  assign out_interp   = out_interp_q;
  assign out_last     = out_last_q;

endmodule

// File: tb/tb_subpix_window_feeder.sv
module tb_subpix_window_feeder;

  localparam int DW = 8;
  localparam int WL = 3;
  localparam int IW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_start;
  logic [15:0]     cfg_pos0, cfg_step;
  logic [11:0]     cfg_nout;
  logic            in_valid, in_ready, in_last;
  logic [DW-1:0]   in_pix;
  logic            out_valid, out_ready, out_last, busy;
  logic [WL*DW-1:0] out_data_col;
  logic [IW-1:0]   out_interp;

  always #5 clk = ~clk;

  subpix_window_feeder #(
    .DATA_DEPTH  (8),
    .SUBPIX_DEPTH(5),
    .SEL_DEPTH   (1),
    .POS_W       (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_pos0    (cfg_pos0),
    .cfg_step    (cfg_step),
    .cfg_nout    (cfg_nout),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pix      (in_pix),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data_col(out_data_col),
    .out_interp  (out_interp),
    .out_last    (out_last),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Edge counter and handshake counter used for latency and stray-output checks.
  int cyc_now = 0;
  int hs_cnt  = 0;
  always @(posedge clk) begin
    cyc_now <= cyc_now + 1;
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  logic [DW-1:0]    line_pix[$];
  int               exp_interp[$];
  logic [WL*DW-1:0] exp_col[$];
  logic             exp_last[$];
  int acc_cnt, acc_at_last, stall_err, overlap_err, third_acc_edge, first_ov_edge;

  // Reference: output n sits at P = pos0 + n*step, window starts at pair 2*(P/64),
  // window pixel k is line pixel min(B+k, last index).
  function automatic void model(input int pos0, input int step, input int nout);
    int p, b, idx, npix;
    logic [WL*DW-1:0] col;
    npix = line_pix.size();
    exp_interp.delete(); exp_col.delete(); exp_last.delete();
    for (int n = 0; n < nout; n++) begin
      p = (pos0 + n * step) % 65536;
      b = (p / 64) * 2;
      col = '0;
      for (int k = 0; k < WL; k++) begin
        idx = b + k;
        if (idx > npix - 1) idx = npix - 1;
        col[k*DW +: DW] = line_pix[idx];
      end
      exp_interp.push_back(p % 64);
      exp_col.push_back(col);
      exp_last.push_back(n == nout - 1);
    end
  endfunction

  task automatic run_line(input int pos0, input int step, input int nout, input int ready_pct,
                          input int valid_pct, input bit glitch, input string tag);
    int npix, hs_base, w;
    npix = line_pix.size();
    acc_cnt = 0; acc_at_last = -1; stall_err = 0; overlap_err = 0;
    third_acc_edge = -1; first_ov_edge = -1;
    out_ready = 1'b1;
    @(negedge clk);
    hs_base   = hs_cnt;
    cfg_pos0  = 16'(pos0);
    cfg_step  = 16'(step);
    cfg_nout  = 12'(nout);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    fork
      begin : drv
        int i = 0;
        int c = 0;
        while (i < npix && c < 6000) begin
          @(negedge clk);
          in_valid = ($urandom_range(0, 99) < valid_pct);
          in_pix   = line_pix[i];
          in_last  = (i == npix - 1);
          #1;
          if (in_valid && in_ready) begin
            i++;
            acc_cnt++;
            if (acc_cnt == WL) third_acc_edge = cyc_now + 1;
          end
          c++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      begin : mon
        int got = 0;
        int c = 0;
        bit held = 0;
        logic [WL*DW-1:0] hc;
        logic [IW-1:0] hi;
        logic hl;
        while (got < nout && c < 6000) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 99) < ready_pct);
          #1;
          if (out_valid && in_ready) overlap_err++;
          if (out_valid) begin
            if (first_ov_edge < 0) first_ov_edge = cyc_now;
            if (held && (out_data_col !== hc || out_interp !== hi || out_last !== hl))
              stall_err++;
            if (out_ready) begin
              check($sformatf("%s.col[%0d]", tag, got), 64'(out_data_col), 64'(exp_col[got]));
              check($sformatf("%s.interp[%0d]", tag, got), 64'(out_interp),
                    64'(exp_interp[got]));
              check($sformatf("%s.last[%0d]", tag, got), 64'(out_last), 64'(exp_last[got]));
              got++;
              held = 0;
              if (got == nout) acc_at_last = acc_cnt;
            end else begin
              held = 1; hc = out_data_col; hi = out_interp; hl = out_last;
            end
          end
          c++;
        end
        out_ready = 1'b1;
        check({tag, ".out_count"}, 64'(got), 64'(nout));
      end
      begin : glt
        if (glitch) begin
          repeat (4) @(negedge clk);
          cfg_pos0 = 16'h1234; cfg_step = 16'hffff; cfg_nout = 12'd0; cfg_start = 1'b1;
          @(negedge clk);
          cfg_start = 1'b0;
        end
      end
    join
    w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".idle"}, 64'(busy), 64'(0));
    check({tag, ".accepted"}, 64'(acc_cnt), 64'(npix));
    check({tag, ".handshakes"}, 64'(hs_cnt - hs_base), 64'(nout));
    check({tag, ".stall_stable"}, 64'(stall_err), 64'(0));
    check({tag, ".no_input_in_emit"}, 64'(overlap_err), 64'(0));
  endtask

  task automatic rand_line(input int nout, input int step, input int ready_pct,
                           input int valid_pct, input bit glitch, input string tag);
    int pos0, bmax, npix;
    pos0 = $urandom_range(0, 200);
    bmax = ((pos0 + (nout - 1) * step) / 64) * 2;
    npix = $urandom_range(1, bmax + 5);
    line_pix.delete();
    for (int i = 0; i < npix; i++) line_pix.push_back(DW'($urandom_range(0, 255)));
    model(pos0, step, nout);
    run_line(pos0, step, nout, ready_pct, valid_pct, glitch, tag);
  endtask

  typedef struct {
    int               pos0;
    int               step;
    int               nout;
    int               npix;
    logic [DW-1:0]    pix [8];
    int               interp [4];
    logic [WL*DW-1:0] col [4];
    int               acc_last;
  } vec_t;

  vec_t vt [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, seen, rdy_hi;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_pos0 = '0; cfg_step = '0; cfg_nout = '0;
    in_valid = 1'b0; in_pix = '0; in_last = 1'b0; out_ready = 1'b0;

    vt[0].pos0 = 0;  vt[0].step = 32; vt[0].nout = 4; vt[0].npix = 6;
    vt[0].pix = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd0, 8'd0};
    vt[0].interp = '{0, 32, 0, 32};
    vt[0].col = '{24'h1e140a, 24'h1e140a, 24'h32281e, 24'h32281e};
    vt[0].acc_last = -1;
    vt[1].pos0 = 96; vt[1].step = 16; vt[1].nout = 2; vt[1].npix = 3;
    vt[1].pix = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vt[1].interp = '{32, 48, 0, 0};
    vt[1].col = '{24'h030303, 24'h030303, 24'h0, 24'h0};
    vt[1].acc_last = 3;
    vt[2].pos0 = 5;  vt[2].step = 0;  vt[2].nout = 3; vt[2].npix = 5;
    vt[2].pix = '{8'd7, 8'd8, 8'd9, 8'd11, 8'd12, 8'd0, 8'd0, 8'd0};
    vt[2].interp = '{5, 5, 5, 0};
    vt[2].col = '{24'h090807, 24'h090807, 24'h090807, 24'h0};
    vt[2].acc_last = 3;
    vt[3].pos0 = 0;  vt[3].step = 32; vt[3].nout = 0; vt[3].npix = 8;
    vt[3].pix = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    vt[3].interp = '{0, 0, 0, 0};
    vt[3].col = '{24'h0, 24'h0, 24'h0, 24'h0};
    vt[3].acc_last = -1;

    repeat (3) @(negedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.out_valid", 64'(out_valid), 64'(0));
    check("reset.in_ready", 64'(in_ready), 64'(0));
    check("reset.out_data_col", 64'(out_data_col), 64'(0));
    check("reset.out_interp", 64'(out_interp), 64'(0));
    check("reset.out_last", 64'(out_last), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed lines with hand-computed expectations.
    for (int v = 0; v < 4; v++) begin
      line_pix.delete();
      exp_interp.delete(); exp_col.delete(); exp_last.delete();
      for (int i = 0; i < vt[v].npix; i++) line_pix.push_back(vt[v].pix[i]);
      for (int n = 0; n < vt[v].nout; n++) begin
        exp_interp.push_back(vt[v].interp[n]);
        exp_col.push_back(vt[v].col[n]);
        exp_last.push_back(n == vt[v].nout - 1);
      end
      run_line(vt[v].pos0, vt[v].step, vt[v].nout, 100, 100, 1'b0, $sformatf("vec%0d", v));
      if (vt[v].acc_last >= 0)
        check($sformatf("vec%0d.accepted_before_drain", v), 64'(acc_at_last),
              64'(vt[v].acc_last));
      if (v == 0) begin
        lat = first_ov_edge - third_acc_edge;
        check("vec0.first_output_latency", 64'(lat >= 1 && lat <= 2), 64'(1));
      end
    end

    // Long stalled line with an ignored mid-line cfg_start.
    rand_line(100, $urandom_range(1, 64), 50, 70, 1'b1, "rand_stall");
    rand_line($urandom_range(5, 30), 64, 60, 80, 1'b0, "rand_step64");
    rand_line($urandom_range(5, 30), 0, 50, 90, 1'b0, "rand_step0");
    for (int r = 0; r < 4; r++)
      rand_line($urandom_range(1, 30), $urandom_range(0, 64), 70, 60, 1'b0,
                $sformatf("rand%0d", r));

    // Reset while an output is pending.
    line_pix.delete();
    for (int i = 0; i < 6; i++) line_pix.push_back(vt[0].pix[i]);
    @(negedge clk);
    cfg_pos0 = 16'd0; cfg_step = 16'd32; cfg_nout = 12'd4; cfg_start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    seen = 0;
    begin
      int i = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
        @(negedge clk);
        in_valid = 1'b1; in_pix = line_pix[i]; in_last = 1'b0;
        #1;
        if (out_valid) seen = 1;
        else if (in_ready) i++;
      end
    end
    check("rst_mid.reached_emit", 64'(seen), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid.out_valid", 64'(out_valid), 64'(0));
    check("rst_mid.busy", 64'(busy), 64'(0));
    check("rst_mid.in_ready", 64'(in_ready), 64'(0));
    check("rst_mid.out_data_col", 64'(out_data_col), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rdy_hi = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      if (in_ready || busy) rdy_hi++;
    end
    in_valid = 1'b0;
    check("rst_mid.needs_fresh_start", 64'(rdy_hi), 64'(0));
    rand_line($urandom_range(5, 20), $urandom_range(0, 64), 80, 80, 1'b0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
